// File: rtl/jtag_tap_target.sv
// IEEE 1149.1 TAP responder with IR, BYPASS, IDCODE and a user DR. Tdo is registered on the falling TCK edge.
// Latency: the first shift bit appears on the falling edge after entering Shift-xR, and BYPASS delays by one TCK. The design is paced by TCK only and has no backpressure.
module jtag_tap_target #(
    parameter int          IR_WIDTH     = 4,
    parameter int          DR_WIDTH     = 32,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5679
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Tms,
    input  logic                Tdi,
    output logic                Tdo,
    output logic                tdoEnable,
    output logic [3:0]          tapState,
    output logic [IR_WIDTH-1:0] instruction,
    input  logic [DR_WIDTH-1:0] userDataIn,
    output logic [DR_WIDTH-1:0] userDataOut,
    output logic                updateDrPulse
);

    typedef enum logic [3:0] {
        TLR     = 4'hF,
        RTI     = 4'hC,
        SEL_DR  = 4'h7,
        CAP_DR  = 4'h6,
        SH_DR   = 4'h2,
        EX1_DR  = 4'h1,
        PAU_DR  = 4'h3,
        EX2_DR  = 4'h0,
        UPD_DR  = 4'h5,
        SEL_IR  = 4'h4,
        CAP_IR  = 4'hE,
        SH_IR   = 4'hA,
        EX1_IR  = 4'h9,
        PAU_IR  = 4'hB,
        EX2_IR  = 4'h8,
        UPD_IR  = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic [IR_WIDTH-1:0] instr_q;
    logic                bypass_q;
    logic [31:0]         idcode_sr_q;
    logic [DR_WIDTH-1:0] user_sr_q;
    logic [DR_WIDTH-1:0] user_out_q;
    logic                upd_pulse_q;
    logic                tdo_q;
    logic                tdo_en_q;

    logic sel_idcode;
    logic sel_user;
    logic shifting;
    logic tdo_bit;

    // Any code other than IDCODE/USER (including all ones) selects BYPASS
    assign sel_idcode = (instr_q == IR_IDCODE);
    assign sel_user   = (instr_q == IR_USER);
    assign shifting   = (state_q == SH_IR) || (state_q == SH_DR);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:     state_d = Tms ? TLR    : RTI;
            RTI:     state_d = Tms ? SEL_DR : RTI;
            SEL_DR:  state_d = Tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = Tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = Tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = Tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = Tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = Tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = Tms ? SEL_DR : RTI;
            SEL_IR:  state_d = Tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = Tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = Tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = Tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = Tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = Tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = Tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        tdo_bit = bypass_q;
        if (state_q == SH_IR) begin
            tdo_bit = ir_sr_q[0];
        end else if (sel_user) begin
            tdo_bit = user_sr_q[0];
        end else if (sel_idcode) begin
            tdo_bit = idcode_sr_q[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= TLR;
            ir_sr_q     <= '0;
            instr_q     <= IR_IDCODE;
            bypass_q    <= 1'b0;
            idcode_sr_q <= '0;
            user_sr_q   <= '0;
            user_out_q  <= '0;
            upd_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            upd_pulse_q <= 1'b0;
            unique case (state_q)
                CAP_IR: ir_sr_q <= IR_CAPTURE;
                SH_IR:  ir_sr_q <= {Tdi, ir_sr_q[IR_WIDTH-1:1]};
                CAP_DR: begin
                    if (sel_user) begin
                        user_sr_q <= userDataIn;
                    end else if (sel_idcode) begin
                        idcode_sr_q <= IDCODE_VALUE;
                    end else begin
                        bypass_q <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_user) begin
                        user_sr_q <= {Tdi, user_sr_q[DR_WIDTH-1:1]};
                    end else if (sel_idcode) begin
                        idcode_sr_q <= {Tdi, idcode_sr_q[31:1]};
                    end else begin
                        bypass_q <= Tdi;
                    end
                end
                // New instruction becomes visible on the edge leaving Update-IR
                UPD_IR: instr_q <= ir_sr_q;
                default: ;
            endcase
            if (state_d == UPD_DR && sel_user) begin
                user_out_q  <= user_sr_q;
                upd_pulse_q <= 1'b1;
            end
            if (state_d == TLR) begin
                instr_q <= IR_IDCODE;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= shifting;
            tdo_q    <= shifting ? tdo_bit : 1'b0;
        end
    end

    assign Tdo           = tdo_q;
    assign tdoEnable     = tdo_en_q;
    assign tapState      = state_q;
    assign instruction   = instr_q;
    assign userDataOut   = user_out_q;
    assign updateDrPulse = upd_pulse_q;

    a_pulse_in_upd: assert property (@(posedge clk) disable iff (!reset)
        updateDrPulse |-> (tapState == UPD_DR));

endmodule

// File: tb/tb_jtag_tap_target.sv
// Scoreboarded bench for jtag_tap_target: stimulus queues expected Tdo bits, and a falling-edge monitor pops them.
module tb_jtag_tap_target;

    logic        clk;
    logic        reset;
    logic        Tms;
    logic        Tdi;
    logic        Tdo;
    logic        tdoEnable;
    logic [3:0]  tapState;
    logic [3:0]  instruction;
    logic [31:0] userDataIn;
    logic [31:0] userDataOut;
    logic        updateDrPulse;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b1;
    logic exp_q[$];

    jtag_tap_target #(
        .IR_WIDTH    (4),
        .DR_WIDTH    (32),
        .IDCODE_VALUE(32'h1234_5679)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Tms          (Tms),
        .Tdi          (Tdi),
        .Tdo          (Tdo),
        .tdoEnable    (tdoEnable),
        .tapState     (tapState),
        .instruction  (instruction),
        .userDataIn   (userDataIn),
        .userDataOut  (userDataOut),
        .updateDrPulse(updateDrPulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tms sequences from TLR to each of the 16 states, applied LSB first
    localparam logic [3:0] WALK_STATE [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                                               4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    localparam int         WALK_LEN   [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    localparam logic [7:0] WALK_TMS   [16] = '{8'b0, 8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010,
                                               8'b01010, 8'b101010, 8'b11010, 8'b110, 8'b0110,
                                               8'b00110, 8'b10110, 8'b010110, 8'b1010110, 8'b110110};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tck(input logic tms, input logic tdi);
        @(negedge clk);
        #1;
        Tms = tms;
        Tdi = tdi;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic goto_shift(input bit ir);
        tck(1'b1, 1'b0);
        if (ir) tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    task automatic shift_bits(input int n, input logic [31:0] din, input bit exit_last);
        for (int i = 0; i < n; i++) tck(exit_last && (i == n - 1), din[i]);
    endtask

    task automatic scan(input bit ir, input int n, input logic [31:0] din, input logic [31:0] exp);
        push_exp(n, exp);
        goto_shift(ir);
        shift_bits(n, din, 1'b1);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
    endtask

    // Monitor: every falling edge with tdoEnable high must match the next queued bit
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && tdoEnable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("tdo_unexpected_enable", 32'(tdoEnable), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdo_bit", 32'(Tdo), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq;
        reset      = 1'b1;
        Tms        = 1'b1;
        Tdi        = 1'b0;
        userDataIn = 32'h0;
        #2 reset = 1'b0;
        #3;
        @(negedge clk);
        #3;
        chk("rst_state", 32'(tapState), 32'hF);
        chk("rst_instr", 32'(instruction), 32'h1);
        chk("rst_tdo", 32'(Tdo), 32'h0);
        chk("rst_tdoen", 32'(tdoEnable), 32'h0);
        chk("rst_udo", userDataOut, 32'h0);
        chk("rst_pulse", 32'(updateDrPulse), 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;

        tck(1'b0, 1'b0);
        chk("rti_after_reset", 32'(tapState), 32'hC);
        scan(1'b0, 32, 32'h0, 32'h1234_5679);
        chk("idcode_no_udo", userDataOut, 32'h0);
        chk("idcode_no_pulse", 32'(updateDrPulse), 32'h0);

        scan(1'b1, 4, 32'hF, 32'h1);
        chk("instr_bypass", 32'(instruction), 32'hF);
        scan(1'b0, 4, 32'b1101, 32'b1010);

        scan(1'b1, 4, 32'h2, 32'h1);
        chk("instr_user", 32'(instruction), 32'h2);
        userDataIn = 32'hCAFE_F00D;
        push_exp(32, 32'hCAFE_F00D);
        goto_shift(1'b0);
        shift_bits(32, 32'hA5A5_0001, 1'b1);
        chk("user_before_upd", userDataOut, 32'h0);
        tck(1'b1, 1'b0);
        chk("user_upd_state", 32'(tapState), 32'h5);
        chk("user_pulse_hi", 32'(updateDrPulse), 32'h1);
        chk("user_udo", userDataOut, 32'hA5A5_0001);
        tck(1'b0, 1'b0);
        chk("user_pulse_lo", 32'(updateDrPulse), 32'h0);

        userDataIn = 32'h0F1E_2D3C;
        push_exp(32, 32'h0F1E_2D3C);
        goto_shift(1'b0);
        shift_bits(10, 32'h1357_9BDF, 1'b1);
        tck(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tck(1'b0, 1'b1);
        chk("pause_state", 32'(tapState), 32'h3);
        tck(1'b1, 1'b0);
        chk("ex2_state", 32'(tapState), 32'h0);
        tck(1'b0, 1'b0);
        shift_bits(22, 32'h1357_9BDF >> 10, 1'b1);
        tck(1'b1, 1'b0);
        chk("pause_pulse", 32'(updateDrPulse), 32'h1);
        chk("pause_udo", userDataOut, 32'h1357_9BDF);
        tck(1'b0, 1'b0);

        tck(1'b1, 1'b0);
        chk("seldr_instr_kept", 32'(instruction), 32'h2);
        for (int i = 0; i < 4; i++) tck(1'b1, 1'b0);
        chk("tlr_state", 32'(tapState), 32'hF);
        chk("tlr_instr_forced", 32'(instruction), 32'h1);

        mon_en = 1'b0;
        for (int s = 0; s < 16; s++) begin
            seq = WALK_TMS[s];
            for (int j = 0; j < WALK_LEN[s]; j++) tck(seq[j], 1'b0);
            chk($sformatf("walk_reach_%h", WALK_STATE[s]), 32'(tapState), 32'(WALK_STATE[s]));
            for (int j = 0; j < 5; j++) tck(1'b1, 1'b0);
            chk($sformatf("walk_tlr_from_%h", WALK_STATE[s]), 32'(tapState), 32'hF);
            chk($sformatf("walk_instr_from_%h", WALK_STATE[s]), 32'(instruction), 32'h1);
        end
        @(negedge clk);
        #3 mon_en = 1'b1;

        tck(1'b0, 1'b0);
        scan(1'b1, 4, 32'h2, 32'h1);
        userDataIn = 32'h0000_00F0;
        scan(1'b0, 32, 32'hFFFF_FFFF, 32'h0000_00F0);
        chk("ones_udo", userDataOut, 32'hFFFF_FFFF);
        userDataIn = 32'h0000_002D;
        push_exp(6, 32'h2D);
        goto_shift(1'b0);
        shift_bits(6, 32'h0, 1'b0);
        chk("mid_shift_state", 32'(tapState), 32'h2);
        chk("mid_shift_tdoen", 32'(tdoEnable), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("abort_state", 32'(tapState), 32'hF);
        chk("abort_instr", 32'(instruction), 32'h1);
        chk("abort_tdo", 32'(Tdo), 32'h0);
        chk("abort_tdoen", 32'(tdoEnable), 32'h0);
        chk("abort_udo", userDataOut, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        tck(1'b0, 1'b0);
        chk("post_abort_rti", 32'(tapState), 32'hC);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
